// File: rtl/random_drop_spawner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// random_drop_spawner : arms, spawns and drops one falling bonus object
// Revision 1.0
// ----------------------------------------------------------------------------
module random_drop_spawner #(
  parameter int SIZE_BITS    = 8,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 607,
  parameter int Y_START      = 0,
  parameter int Y_END        = 479,
  parameter int FALL_SPEED   = 2,
  parameter int DELAY_FRAMES = 120
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic [SIZE_BITS-1:0] rand_val,
  input  logic                 spawn_enable,
  input  logic                 caught,
  output logic                 drop_active,
  output logic [10:0]          topLeftX,
  output logic [10:0]          topLeftY,
  output logic                 caught_pulse,
  output logic                 missed_pulse
);

  localparam int RANGE = X_MAX - X_MIN + 1;
  localparam int PW    = SIZE_BITS + 11;
  localparam int CNT_W = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FALL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
  logic [10:0]      x_q, x_d;
  logic [10:0]      y_q, y_d;
  logic             caught_pulse_q, caught_pulse_d;
  logic             missed_pulse_q, missed_pulse_d;

  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_shifted;
  logic [10:0]      spawn_x;
  logic [11:0]      y_step;
  logic             past_bottom;

  // Full-width product keeps the scaled column inside [X_MIN, X_MAX].
  assign prod         = PW'(rand_val) * PW'(RANGE);
  assign prod_shifted = prod >> SIZE_BITS;
  assign spawn_x      = 11'(prod_shifted) + 11'(X_MIN);
  assign y_step       = {1'b0, y_q} + 12'(FALL_SPEED);
  assign past_bottom  = (y_step > 12'(Y_END));

  always_comb begin
    state_d        = state_q;
    delay_cnt_d    = delay_cnt_q;
    x_d            = x_q;
    y_d            = y_q;
    caught_pulse_d = 1'b0;
    missed_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (spawn_enable) begin
          delay_cnt_d = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (!spawn_enable) begin
          state_d = IDLE;
        end else if (startOfFrame) begin
          if (delay_cnt_q == CNT_W'(DELAY_FRAMES - 1)) begin
            x_d     = spawn_x;
            y_d     = 11'(Y_START);
            state_d = FALL;
          end else begin
            delay_cnt_d = delay_cnt_q + 1'b1;
          end
        end
      end
      FALL: begin
        // A catch outranks a bottom-exceeding tick in the same cycle.
        if (caught) begin
          caught_pulse_d = 1'b1;
          delay_cnt_d    = '0;
          state_d        = spawn_enable ? WAIT : IDLE;
        end else if (startOfFrame) begin
          if (past_bottom) begin
            missed_pulse_d = 1'b1;
            delay_cnt_d    = '0;
            state_d        = spawn_enable ? WAIT : IDLE;
          end else begin
            y_d = y_step[10:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      delay_cnt_q    <= '0;
      x_q            <= 11'(X_MIN);
      y_q            <= 11'(Y_START);
      caught_pulse_q <= 1'b0;
      missed_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      delay_cnt_q    <= delay_cnt_d;
      x_q            <= x_d;
      y_q            <= y_d;
      caught_pulse_q <= caught_pulse_d;
      missed_pulse_q <= missed_pulse_d;
    end
  end

  assign drop_active  = (state_q == FALL);
  assign topLeftX     = x_q;
  assign topLeftY     = y_q;
  assign caught_pulse = caught_pulse_q;
  assign missed_pulse = missed_pulse_q;

endmodule
`default_nettype wire
